// File: rtl/spi_txn_scheduler_if.sv
// Command, response and SPI-master handshake bundle for spi_txn_scheduler.
// The slave modport is the scheduler's view; the master modport is the
// surrounding logic (host + SPI master) that drives commands and ready.
interface spi_txn_scheduler_if #(
   parameter int WORD_SIZE   = 16,
   parameter int SLAVE_COUNT = 2
);
   localparam int CSW = $clog2(SLAVE_COUNT);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [CSW-1:0]       cmd_cs;
   logic [WORD_SIZE-1:0] cmd_data;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [CSW-1:0]       rsp_cs;
   logic [WORD_SIZE-1:0] rsp_data;
   logic                 rsp_err;

   logic                 mst_start;
   logic [CSW-1:0]       mst_chip_select;
   logic [WORD_SIZE-1:0] mst_tx_data;
   logic                 mst_ready;
   logic [WORD_SIZE-1:0] mst_rx_data;

   modport slave (
      input  cmd_valid, cmd_cs, cmd_data, rsp_ready, mst_ready, mst_rx_data,
      output cmd_ready, rsp_valid, rsp_cs, rsp_data, rsp_err,
             mst_start, mst_chip_select, mst_tx_data
   );

   modport master (
      output cmd_valid, cmd_cs, cmd_data, rsp_ready, mst_ready, mst_rx_data,
      input  cmd_ready, rsp_valid, rsp_cs, rsp_data, rsp_err,
             mst_start, mst_chip_select, mst_tx_data
   );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Front-end for the SPI master: queues {slave, word} commands, issues them
// one at a time, holds tx data/chip select for the whole transfer, returns
// tagged responses through a fall-through FIFO, enforces an idle gap after
// every transfer and abandons transfers on a stalled master.
module spi_txn_scheduler #(
   parameter int WORD_SIZE      = 16,
   parameter int SLAVE_COUNT    = 2,
   parameter int CMD_DEPTH      = 4,
   parameter int RSP_DEPTH      = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   spi_txn_scheduler_if.slave  bus,
   output logic                busy,
   output logic                timeout_err
);
   localparam int CSW = $clog2(SLAVE_COUNT);
   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);
   localparam int WDW = $clog2(TIMEOUT_CYCLES);
   localparam int GPW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

   typedef struct packed {
      logic [CSW-1:0]       cs;
      logic [WORD_SIZE-1:0] data;
   } cmd_t;

   typedef struct packed {
      logic                 err;
      logic [CSW-1:0]       cs;
      logic [WORD_SIZE-1:0] data;
   } rsp_t;

   state_t         state, state_nxt;
   logic [WDW-1:0] wd_cnt;
   logic [GPW-1:0] gap_cnt;

   cmd_t           cmd_mem [CMD_DEPTH];
   logic [CAW-1:0] cmd_wr_ptr, cmd_rd_ptr;
   logic [CAW:0]   cmd_count;
   logic           cmd_full, cmd_push, cmd_pop;

   rsp_t           rsp_mem [RSP_DEPTH];
   logic [RAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
   logic [RAW:0]   rsp_count;
   logic           rsp_push, rsp_pop;
   rsp_t           rsp_in, rsp_head;

   assign cmd_full      = (cmd_count == (CAW+1)'(CMD_DEPTH));
   assign cmd_push      = bus.cmd_valid && !cmd_full;
   assign bus.cmd_ready = !cmd_full;

   assign rsp_pop       = (rsp_count != '0) && bus.rsp_ready;
   assign rsp_head      = rsp_mem[rsp_rd_ptr];
   assign bus.rsp_valid = (rsp_count != '0);
   assign bus.rsp_cs    = rsp_head.cs;
   assign bus.rsp_data  = rsp_head.data;
   assign bus.rsp_err   = rsp_head.err;

   assign bus.mst_start = (state == ST_ISSUE);
   assign busy          = (state != ST_IDLE) || (cmd_count != '0);

   // Next-state and per-cycle strobes of the transfer sequencer.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt   = state;
      cmd_pop     = 1'b0;
      rsp_push    = 1'b0;
      rsp_in      = '0;
      timeout_err = 1'b0;
      case (state)
         ST_IDLE: begin
            // Issuing only with a free response slot reserves room for the
            // eventual push, so the response FIFO can never overflow.
            if ((cmd_count != '0) && (rsp_count != (RAW+1)'(RSP_DEPTH)) && bus.mst_ready) begin
               cmd_pop   = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (bus.mst_ready) begin
               rsp_push  = 1'b1;
               rsp_in    = '{err: 1'b0, cs: bus.mst_chip_select, data: bus.mst_rx_data};
               state_nxt = ST_GAP;
            end else if (wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
               rsp_push    = 1'b1;
               rsp_in      = '{err: 1'b1, cs: bus.mst_chip_select, data: '0};
               timeout_err = 1'b1;
               state_nxt   = ST_GAP;
            end
         end
         ST_GAP: if (gap_cnt == '0) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, watchdog, gap counter and the latched transfer word.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
         state               <= ST_IDLE;
         wd_cnt              <= '0;
         gap_cnt             <= '0;
         bus.mst_tx_data     <= '0;
         bus.mst_chip_select <= '0;
      end else begin
         state <= state_nxt;
         if (cmd_pop) begin
            bus.mst_tx_data     <= cmd_mem[cmd_rd_ptr].data;
            bus.mst_chip_select <= cmd_mem[cmd_rd_ptr].cs;
         end
         if (state == ST_ISSUE)     wd_cnt <= '0;
         else if (state == ST_WAIT) wd_cnt <= wd_cnt + WDW'(1);
         if (state == ST_WAIT && state_nxt == ST_GAP)   gap_cnt <= GPW'(GAP_CYCLES);
         else if (state == ST_GAP && gap_cnt != '0)     gap_cnt <= gap_cnt - GPW'(1);
      end
   end

   // Command FIFO pointers and occupancy; no push when full, even alongside a pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_count  <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
         if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
         case ({cmd_push, cmd_pop})
            2'b10:   cmd_count <= cmd_count + (CAW+1)'(1);
            2'b01:   cmd_count <= cmd_count - (CAW+1)'(1);
            default: ;
         endcase
      end
   end

   // Command FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays are not reset; occupancy counters guard every read.
      if (cmd_push) cmd_mem[cmd_wr_ptr] <= '{cs: bus.cmd_cs, data: bus.cmd_data};
   end

   // Response FIFO pointers and occupancy; push and pop together keep the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_wr_ptr <= '0;
         rsp_rd_ptr <= '0;
         rsp_count  <= '0;
      end else begin
         if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RAW'(1);
         if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RAW'(1);
         case ({rsp_push, rsp_pop})
            2'b10:   rsp_count <= rsp_count + (RAW+1)'(1);
            2'b01:   rsp_count <= rsp_count - (RAW+1)'(1);
            default: ;
         endcase
      end
   end

   // Response FIFO storage.
   always_ff @(posedge clk) begin
      if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_in;
   end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Self-checking bench for spi_txn_scheduler: behavioural SPI master model,
// scoreboard of expected responses, table of command vectors and hand-written
// sequences for full FIFO, backpressure, timeout, gap and mid-transfer reset.
module tb_spi_txn_scheduler;
   localparam int WORD_SIZE      = 16;
   localparam int SLAVE_COUNT    = 2;
   localparam int CMD_DEPTH      = 4;
   localparam int RSP_DEPTH      = 4;
   localparam int GAP_CYCLES     = 2;
   localparam int TIMEOUT_CYCLES = 64;

   typedef struct packed {
      logic        err;
      logic        cs;
      logic [15:0] data;
   } exp_t;

   typedef struct {
      logic        cs;
      logic [15:0] data;
      logic [15:0] exp_rx;
      logic        exp_ready;
   } vec_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic busy, timeout_err;

   spi_txn_scheduler_if #(.WORD_SIZE(WORD_SIZE), .SLAVE_COUNT(SLAVE_COUNT)) bus ();

   spi_txn_scheduler #(
      .WORD_SIZE(WORD_SIZE), .SLAVE_COUNT(SLAVE_COUNT), .CMD_DEPTH(CMD_DEPTH),
      .RSP_DEPTH(RSP_DEPTH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t exp_q[$];
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      else n_pass++;
   endtask

   // Master model knobs and observations.
   int          lat_cfg = 20;
   bit          hang = 0, hold = 0, release_now = 0, use_fixed = 0;
   logic [15:0] rx_fixed = '0;
   int          start_cnt = 0, start_cyc = 0, ready_cyc = 0, last_gap = 0, stable_err = 0;
   logic        cap_cs = 1'b0;
   logic [15:0] cap_tx = '0;

   initial begin : master_model
      int cnt;
      bit active;
      cnt = 0;
      active = 0;
      bus.mst_ready   = 1'b1;
      bus.mst_rx_data = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            bus.mst_ready = 1'b1;
            active = 0;
         end else if (bus.mst_start) begin
            last_gap  = cyc - ready_cyc;
            start_cnt++;
            start_cyc = cyc;
            cap_cs    = bus.mst_chip_select;
            cap_tx    = bus.mst_tx_data;
            bus.mst_ready = 1'b0;
            active = 1;
            cnt = lat_cfg;
         end else if (active) begin
            if (bus.mst_chip_select !== cap_cs || bus.mst_tx_data !== cap_tx) stable_err++;
            if (release_now) begin
               release_now = 0;
               active = 0;
               bus.mst_ready = 1'b1;
            end else if (!hang) begin
               cnt--;
               if (cnt <= 0) begin
                  bus.mst_rx_data = use_fixed ? rx_fixed : ~cap_tx;
                  bus.mst_ready   = 1'b1;
                  ready_cyc = cyc;
                  active = 0;
               end
            end
         end else begin
            bus.mst_ready = !hold;
         end
      end
   end

   // Response consumer: pops while it has credits and checks against the scoreboard.
   int credits = 1000000;
   bit rsp_prev = 0;
   int rsp_rise_cyc = 0;

   initial begin : consumer
      exp_t e;
      bus.rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.rsp_valid && !rsp_prev) rsp_rise_cyc = cyc;
         rsp_prev = bus.rsp_valid;
         bus.rsp_ready = 1'b0;
         if (bus.rsp_valid && credits > 0) begin
            bus.rsp_ready = 1'b1;
            credits--;
            check("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rsp_err_cs_data", {bus.rsp_err, bus.rsp_cs, bus.rsp_data}, e);
            end
         end
      end
   end

   // Timeout pulse monitor.
   int to_cnt = 0, to_cyc = 0;
   always @(negedge clk) if (timeout_err) begin to_cnt++; to_cyc = cyc; end

   int acc_cyc = 0;

   // Pushes one command (called at a negedge, returns at a negedge).
   task automatic push_cmd(input logic cs, input logic [15:0] d, input logic err, input logic [15:0] rx);
      int n;
      bus.cmd_valid = 1'b1;
      bus.cmd_cs    = cs;
      bus.cmd_data  = d;
      n = 0;
      while (!bus.cmd_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", bus.cmd_ready, 1);
      if (bus.cmd_ready) begin
         @(posedge clk);
         exp_q.push_back('{err: err, cs: cs, data: rx});
         @(negedge clk);
         acc_cyc = cyc;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drained(input string name, input int budget);
      for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) @(negedge clk);
      check({name, "_drained"}, {exp_q.size() != 0, busy}, 0);
   endtask

   task automatic wait_starts(input string name, input int target, input int budget);
      for (int i = 0; i < budget && start_cnt < target; i++) @(negedge clk);
      check({name, "_started"}, start_cnt >= target, 1);
   endtask

   task automatic check_reset(input string name);
      check({name, "_mst_start"}, bus.mst_start, 0);
      check({name, "_mst_tx"}, bus.mst_tx_data, 0);
      check({name, "_mst_cs"}, bus.mst_chip_select, 0);
      check({name, "_rsp_valid"}, bus.rsp_valid, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_timeout"}, timeout_err, 0);
      check({name, "_cmd_ready"}, bus.cmd_ready, 1);
   endtask

   task automatic single_a5c3(input string name);
      int base;
      use_fixed = 1;
      rx_fixed  = 16'h1234;
      lat_cfg   = 20;
      base      = start_cnt;
      push_cmd(1'b1, 16'hA5C3, 1'b0, 16'h1234);
      wait_drained(name, 200);
      check({name, "_starts"}, start_cnt - base, 1);
      check({name, "_start_lat"}, start_cyc - acc_cyc, 1);
      check({name, "_cs"}, cap_cs, 1);
      check({name, "_tx"}, cap_tx, 16'hA5C3);
      check({name, "_rsp_lat"}, rsp_rise_cyc - ready_cyc, 1);
      use_fixed = 0;
   endtask

   initial begin : main
      int base, base_to;
      vecs[0] = '{1'b0, 16'h1111, 16'hEEEE, 1'b1};
      vecs[1] = '{1'b1, 16'h2222, 16'hDDDD, 1'b1};
      vecs[2] = '{1'b0, 16'h3C3C, 16'hC3C3, 1'b1};
      vecs[3] = '{1'b1, 16'h8001, 16'h7FFE, 1'b0};
      vecs[4] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0};
      vecs[5] = '{1'b0, 16'h0000, 16'hFFFF, 1'b0};

      bus.cmd_valid = 1'b0;
      bus.cmd_cs    = '0;
      bus.cmd_data  = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // T1: single transfer
      single_a5c3("t1");

      // T2: fill the command FIFO while the master holds ready low
      lat_cfg = 4;
      hold = 1;
      repeat (2) @(negedge clk);
      base = start_cnt;
      for (int i = 0; i < 4; i++) begin
         push_cmd(vecs[i].cs, vecs[i].data, 1'b0, vecs[i].exp_rx);
         check($sformatf("t2_cmd_ready_%0d", i), bus.cmd_ready, vecs[i].exp_ready);
      end
      check("t2_no_start", start_cnt - base, 0);
      hold = 0;
      push_cmd(vecs[4].cs, vecs[4].data, 1'b0, vecs[4].exp_rx);
      check("t2_fifth_after_pop", start_cnt - base >= 1, 1);
      wait_drained("t2", 400);
      check("t2_starts", start_cnt - base, 5);

      // T3: response backpressure parks the FSM after RSP_DEPTH transfers
      lat_cfg = 3;
      credits = 0;
      base = start_cnt;
      for (int i = 0; i < 6; i++) push_cmd(vecs[i].cs, vecs[i].data, 1'b0, vecs[i].exp_rx);
      repeat (40) @(negedge clk);
      check("t3_parked_starts", start_cnt - base, 4);
      check("t3_busy", busy, 1);
      check("t3_rsp_valid", bus.rsp_valid, 1);
      credits = 1;
      repeat (40) @(negedge clk);
      check("t3_one_more", start_cnt - base, 5);
      credits = 1000000;
      wait_drained("t3", 300);
      check("t3_starts", start_cnt - base, 6);

      // T4: stalled master triggers the watchdog
      hang = 1;
      base = start_cnt;
      base_to = to_cnt;
      push_cmd(1'b0, 16'h0F0F, 1'b1, 16'h0000);
      for (int i = 0; i < 200 && to_cnt == base_to; i++) @(negedge clk);
      check("t4_timeout_seen", to_cnt - base_to, 1);
      check("t4_timeout_delay", to_cyc - start_cyc, TIMEOUT_CYCLES);
      push_cmd(1'b1, 16'h4321, 1'b0, 16'hBCDE);
      repeat (30) @(negedge clk);
      check("t4_waits_for_ready", start_cnt - base, 1);
      check("t4_single_pulse", to_cnt - base_to, 1);
      hang = 0;
      release_now = 1;
      wait_drained("t4", 200);
      check("t4_starts", start_cnt - base, 2);

      // T5: idle gap between back-to-back transfers
      lat_cfg = 3;
      base = start_cnt;
      push_cmd(1'b0, 16'h00FF, 1'b0, 16'hFF00);
      push_cmd(1'b1, 16'hF0F0, 1'b0, 16'h0F0F);
      wait_drained("t5", 200);
      check("t5_starts", start_cnt - base, 2);
      check("t5_gap_ge3", last_gap >= 3, 1);

      // T6: reset in the middle of WAIT
      lat_cfg = 30;
      base = start_cnt;
      push_cmd(1'b0, 16'h5555, 1'b0, 16'hAAAA);
      wait_starts("t6", base + 1, 50);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset("t6_reset");
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      single_a5c3("t6_after");

      check("tx_cs_stable", stable_err, 0);
      check("timeout_total", to_cnt, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
